weighted_rr_arbiter: RTL and testbench

- Parametrised successor to the team's fixed 4-way round-robin arbiter.
- Arbitrates N requesters with a registered one-hot grant.
- Each requester has a programmable weight: the number of consecutive cycles it may hold the grant before rotation.
- Sits in front of shared resources (bus port, memory bank, pipeline slot) in the RISC-V datapath.

---
 rtl/wrr_arb_pkg.sv | 20 ++
 rtl/rr_find_next.sv | 43 ++++
 rtl/weighted_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_weighted_rr_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/wrr_arb_pkg.sv
// ---------------------------------------------------------------------------
// wrr_arb_pkg
//   Shared constants and types for the weighted round-robin arbiter.
//   N_DEF / WEIGHT_W_DEF : default requester count and weight-field width.
//   arb_dec_e            : per-cycle arbitration decision (also a handy
//                          debug probe when looking at waveforms).
// Optional feature macro used by the arbiter: WRR_ARB_LOCK_EN.
// ---------------------------------------------------------------------------
package wrr_arb_pkg;

  localparam int N_DEF        = 4;
  localparam int WEIGHT_W_DEF = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_HOLD   = 2'd1,
    ARB_ROTATE = 2'd2
  } arb_dec_e;

endpackage : wrr_arb_pkg

// File: rtl/rr_find_next.sv
// ---------------------------------------------------------------------------
// rr_find_next
//   Purely combinational rotating find-first-set. Scans req starting at
//   index 'start' and wrapping modulo N; the first set bit wins.
// Ports:
//   req     [N]     : request vector
//   start   [IDX_W] : first index examined
//   onehot  [N]     : one-hot of the winner (all-zero if none)
//   idx     [IDX_W] : binary index of the winner (0 if none)
//   found           : any request set
// ---------------------------------------------------------------------------
module rr_find_next #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int j;

  // NOTE: every output gets a default before the loop so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IDX_W'(j);
      end
    end
  end

endmodule : rr_find_next

// File: rtl/weighted_rr_arbiter.sv
// ---------------------------------------------------------------------------
// weighted_rr_arbiter
//   N-way round-robin arbiter with a registered one-hot grant. Each
//   requester may hold the grant for up to weight[i] consecutive cycles
//   (0 counts as 1) before the grant rotates. The weight is captured when
//   a burst starts, so later changes only affect the next burst.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-low reset
//   req    [N]   : request vector
//   weight [N*WEIGHT_W] : packed weights, field i = weight[i*WEIGHT_W +: WEIGHT_W]
//   lock         : (only with WRR_ARB_LOCK_EN) keep the current owner
//   grant  [N]   : registered one-hot grant or zero
//   grant_valid  : grant is non-zero
//   grant_idx    : index of the granted requester, 0 when idle
// Optional feature: define WRR_ARB_LOCK_EN to add the lock input.
// ---------------------------------------------------------------------------
module weighted_rr_arbiter
  import wrr_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
`ifdef WRR_ARB_LOCK_EN
  input  logic                  lock,
`endif
  output logic [N-1:0]          grant,
  output logic                  grant_valid,
  output logic [IDX_W-1:0]      grant_idx
);

  localparam logic [WEIGHT_W-1:0] W_ONE   = WEIGHT_W'(1);
  localparam logic [WEIGHT_W:0]   CNT_ONE = (WEIGHT_W + 1)'(1);

  logic [N-1:0]        r_grant;
  logic                r_valid;
  logic [IDX_W-1:0]    r_owner;
  logic [IDX_W-1:0]    r_ptr;
  logic [WEIGHT_W-1:0] r_cnt;
  logic [WEIGHT_W-1:0] r_weight;

  logic [WEIGHT_W-1:0] w_weight_arr [N];
  logic [IDX_W-1:0]    w_start;
  logic [N-1:0]        w_next_onehot;
  logic [IDX_W-1:0]    w_next_idx;
  logic                w_found;
  logic [WEIGHT_W:0]   w_cnt_inc;
  logic                w_burst_left;
  logic                w_lock_hold;
  logic [WEIGHT_W-1:0] w_new_weight;
  arb_dec_e            w_dec;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_weight_arr[g] = weight[g*WEIGHT_W +: WEIGHT_W];
  end

  // Search begins just after the last owner, so the owner itself is
  // examined last and a sole requester still gets re-granted.
  assign w_start = (r_ptr == IDX_W'(N - 1)) ? '0 : r_ptr + IDX_W'(1);

  rr_find_next #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_find (
    .req    (req),
    .start  (w_start),
    .onehot (w_next_onehot),
    .idx    (w_next_idx),
    .found  (w_found)
  );

  // One extra bit so cnt+1 cannot wrap before the compare.
  assign w_cnt_inc    = {1'b0, r_cnt} + CNT_ONE;
  assign w_burst_left = w_cnt_inc < {1'b0, r_weight};

`ifdef WRR_ARB_LOCK_EN
  assign w_lock_hold = lock;
`else
  assign w_lock_hold = 1'b0;
`endif

  assign w_new_weight = (w_weight_arr[w_next_idx] == '0) ? W_ONE
                                                         : w_weight_arr[w_next_idx];

  always_comb begin
    w_dec = ARB_IDLE;
    if (w_found) begin
      if (r_valid && req[r_owner] && (w_burst_left || w_lock_hold))
        w_dec = ARB_HOLD;
      else
        w_dec = ARB_ROTATE;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous, hence only clk in
  // the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant  <= '0;
      r_valid  <= 1'b0;
      r_owner  <= '0;
      r_ptr    <= IDX_W'(N - 1);
      r_cnt    <= '0;
      r_weight <= W_ONE;
    end else begin
      case (w_dec)
        ARB_HOLD: begin
          // Under lock the count saturates at weight-1 so that dropping
          // lock rotates on the very next edge.
          if (w_burst_left) r_cnt <= w_cnt_inc[WEIGHT_W-1:0];
        end
        ARB_ROTATE: begin
          r_grant  <= w_next_onehot;
          r_valid  <= 1'b1;
          r_owner  <= w_next_idx;
          r_ptr    <= w_next_idx;
          r_cnt    <= '0;
          r_weight <= w_new_weight;
        end
        default: begin
          r_grant <= '0;
          r_valid <= 1'b0;
          r_owner <= '0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_idx   = r_owner;

endmodule : weighted_rr_arbiter

// File: tb/tb_weighted_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_weighted_rr_arbiter
//   Self-checking bench: directed scenarios plus randomized traffic, all
//   compared against a behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_weighted_rr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
`ifdef WRR_ARB_LOCK_EN
  logic            lock;
`endif
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IW-1:0]   grant_idx;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model state
  bit m_valid;
  int m_owner, m_ptr, m_cnt, m_w;

  int seq_w1 [5]  = '{0, 1, 2, 3, 0};
  int seq_wt [10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};

  weighted_rr_arbiter #(.N(N), .WEIGHT_W(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .weight      (weight),
`ifdef WRR_ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int field(input int i);
    return int'(weight[i*WW +: WW]);
  endfunction

  // Arbitration rules applied to the inputs present at the edge.
  task automatic model_step();
    bit lk;
    lk = 1'b0;
`ifdef WRR_ARB_LOCK_EN
    lk = lock;
`endif
    if (!rst) begin
      m_valid = 0; m_owner = 0; m_cnt = 0; m_ptr = N - 1; m_w = 1;
    end else if (req == '0) begin
      m_valid = 0; m_owner = 0; m_cnt = 0;
    end else if (m_valid && req[m_owner] && (m_cnt + 1 < m_w || lk)) begin
      if (m_cnt + 1 < m_w) m_cnt = m_cnt + 1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req[c]) begin
          m_owner = c; m_ptr = c; m_cnt = 0; m_valid = 1;
          m_w = (field(c) == 0) ? 1 : field(c);
          break;
        end
      end
    end
  endtask

  // One clock: model follows the edge, DUT sampled 1 ns later.
  task automatic tick();
    logic [N-1:0] req_at_edge;
    req_at_edge = req;
    @(posedge clk);
    model_step();
    #1;
    check("grant",   32'(grant),       m_valid ? (32'd1 << m_owner) : 32'd0);
    check("valid",   32'(grant_valid), 32'(m_valid));
    check("idx",     32'(grant_idx),   32'(m_owner));
    check("no_req",  32'(grant & ~req_at_edge), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    repeat (cycles) tick();
    rst = 1'b1;
  endtask

  initial begin
    rst    = 1'b0;
    req    = 4'b1111;
    weight = 16'h1111;
`ifdef WRR_ARB_LOCK_EN
    lock   = 1'b0;
`endif
    m_valid = 0; m_owner = 0; m_cnt = 0; m_ptr = N - 1; m_w = 1;
    #2;

    // Reset held 2 cycles with all requests, then plain round robin.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_valid", 32'(grant_valid), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_w1_idx", 32'(grant_idx), 32'(seq_w1[i]));
    end

    // Weighted sequence, w3 = 0 behaves as 1.
    weight = {4'd0, 4'd2, 4'd1, 4'd3};
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("weighted_idx", 32'(grant_idx), 32'(seq_wt[i]));
    end

    // Owner 0 drops after one cycle of a 3-cycle burst.
    do_reset(1);
    req = 4'b1111;
    tick();
    check("drop_first", 32'(grant), 32'b0001);
    req = 4'b0100;
    tick();
    check("drop_rotate", 32'(grant), 32'b0100);
    req = 4'b0101;
    repeat (3) tick();

    // Sole requester, then idle, then wrap-around search.
    weight = 16'h1111;
    req    = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sole_req", 32'(grant), 32'b0100);
    end
    req = 4'b0000;
    tick();
    check("idle_grant", 32'(grant), 32'd0);
    req = 4'b0010;
    tick();
    check("wrap_grant", 32'(grant), 32'b0010);

    // Reset mid-burst, then a fresh 3-cycle burst for requester 0.
    weight = 16'h1113;
    do_reset(1);
    req = 4'b1111;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("mid_rst", 32'(grant), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fresh_burst", 32'(grant), 32'b0001);
    end
    tick();
    check("after_burst", 32'(grant), 32'b0010);

`ifdef WRR_ARB_LOCK_EN
    // Lock on owner 1 with weight 1 holds the grant.
    weight = 16'h1111;
    do_reset(1);
    req = 4'b1111;
    repeat (2) tick();
    lock = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("lock_hold", 32'(grant), 32'b0010);
    end
    lock = 1'b0;
    tick();
    check("lock_release", 32'(grant), 32'b0100);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) != 0);
      req = ($urandom_range(0, 7) == 0) ? 4'b0000 : N'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int f = 0; f < N; f++)
          weight[f*WW +: WW] = ($urandom_range(0, 4) == 0) ? WW'($urandom) : WW'($urandom_range(0, 3));
      end
`ifdef WRR_ARB_LOCK_EN
      lock = ($urandom_range(0, 3) == 0);
`endif
      tick();
      check("onehot", 32'($countones(grant) <= 1), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_weighted_rr_arbiter
